// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Register window of 16 bytes at BASE_ADDR: TXDATA, STATUS, CTRL, reserved.
// Optional parity bit between the data bits and the stop bit is built when
// UART_TX_PARITY_EN is defined (CTRL bit1 then selects odd parity).
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
   parameter int unsigned CLK_DIV    = 868,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRW,
   input  logic [31:0] Addr_in,
   input  logic [31:0] Data_in,
   output logic        hit,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        irq_empty
);

   localparam int unsigned   AW          = $clog2(FIFO_DEPTH);
   localparam int unsigned   CW          = AW + 1;
   localparam logic [15:0]   BAUD_RELOAD = 16'(CLK_DIV - 1);
   localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t        r_state, w_state_next;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count, w_count_next;

   logic          r_ovf, r_tx_en, r_txd, r_irq;
   logic [15:0]   r_baud, w_baud_next;
   logic [7:0]    r_shift, w_shift_next;
   logic [2:0]    r_bitcnt, w_bitcnt_next;
   logic          w_txd_next;

   logic          w_hit, w_wr;
   logic [1:0]    w_off;
   logic          w_empty, w_full, w_busy, w_baud_zero;
   logic          w_pop, w_push_req, w_push, w_ovf_set;
   logic          w_odd_rd;
   logic [7:0]    w_count8;
   logic          w_unused;

`ifdef UART_TX_PARITY_EN
   logic          r_odd, r_par, w_par_next;
   assign w_odd_rd = r_odd;
`else
   assign w_odd_rd = 1'b0;
`endif

   // Address decode and FIFO status
   assign w_hit       = (Addr_in[31:4] == BASE_ADDR[31:4]);
   assign w_wr        = MemRW & w_hit;
   assign w_off       = Addr_in[3:2];
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == DEPTH_C);
   assign w_busy      = (r_state != S_IDLE);
   assign w_baud_zero = (r_baud == '0);
   assign w_count8    = 8'(r_count);

   // A full FIFO still accepts a byte when the head leaves on the same edge
   assign w_push_req   = w_wr && (w_off == 2'd0);
   assign w_push       = w_push_req && (!w_full || w_pop);
   assign w_ovf_set    = w_push_req && !w_push;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

   assign w_unused = ^{Addr_in[1:0], Data_in[31:8]};

   assign hit       = w_hit;
   assign txd       = r_txd;
   assign irq_empty = r_irq;

   // Next-state, baud/shift datapath and registered txd level for the FSM
   always_comb begin
      w_state_next  = r_state;
      w_baud_next   = r_baud;
      w_shift_next  = r_shift;
      w_bitcnt_next = r_bitcnt;
      w_pop         = 1'b0;
      w_txd_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
      w_par_next    = r_par;
`endif
      case (r_state)
         S_IDLE: begin
            if (r_tx_en && !w_empty) begin
               w_pop         = 1'b1;
               w_shift_next  = r_mem[r_rptr];
               w_baud_next   = BAUD_RELOAD;
               w_bitcnt_next = '0;
               w_state_next  = S_START;
`ifdef UART_TX_PARITY_EN
               w_par_next    = (^r_mem[r_rptr]) ^ r_odd;
`endif
            end
         end
         S_START: begin
            if (w_baud_zero) begin
               w_baud_next  = BAUD_RELOAD;
               w_state_next = S_DATA;
            end else begin
               w_baud_next = r_baud - 16'd1;
            end
         end
         S_DATA: begin
            if (w_baud_zero) begin
               w_shift_next  = {1'b0, r_shift[7:1]};
               w_bitcnt_next = r_bitcnt + 3'd1;
               w_baud_next   = BAUD_RELOAD;
               if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_next = S_PARITY;
`else
                  w_state_next = S_STOP;
`endif
               end
            end else begin
               w_baud_next = r_baud - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_baud_zero) begin
               w_baud_next  = BAUD_RELOAD;
               w_state_next = S_STOP;
            end else begin
               w_baud_next = r_baud - 16'd1;
            end
         end
`endif
         S_STOP: begin
            if (w_baud_zero) begin
               if (r_tx_en && !w_empty) begin
                  w_pop         = 1'b1;
                  w_shift_next  = r_mem[r_rptr];
                  w_baud_next   = BAUD_RELOAD;
                  w_bitcnt_next = '0;
                  w_state_next  = S_START;
`ifdef UART_TX_PARITY_EN
                  w_par_next    = (^r_mem[r_rptr]) ^ r_odd;
`endif
               end else begin
                  w_state_next = S_IDLE;
               end
            end else begin
               w_baud_next = r_baud - 16'd1;
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      // txd is registered, so derive the level from the state being entered
      case (w_state_next)
         S_START:  w_txd_next = 1'b0;
         S_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_txd_next = w_par_next;
`endif
         default:  w_txd_next = 1'b1;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Datapath, FIFO pointers and control/status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_tx_en  <= 1'b1;
         r_baud   <= '0;
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_txd    <= 1'b1;
         r_irq    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_odd    <= 1'b0;
         r_par    <= 1'b0;
`endif
      end else begin
         r_baud   <= w_baud_next;
         r_shift  <= w_shift_next;
         r_bitcnt <= w_bitcnt_next;
         r_txd    <= w_txd_next;
         r_count  <= w_count_next;
         r_irq    <= (w_count_next == '0) && (w_state_next == S_IDLE);
`ifdef UART_TX_PARITY_EN
         r_par    <= w_par_next;
`endif
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end else if (w_wr && (w_off == 2'd1) && Data_in[3]) begin
            r_ovf <= 1'b0;
         end
         if (w_wr && (w_off == 2'd2)) begin
            r_tx_en <= Data_in[0];
`ifdef UART_TX_PARITY_EN
            r_odd   <= Data_in[1];
`endif
         end
      end
   end

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= Data_in[7:0];
   end

   // Combinational read mux for the single-cycle load path
   always_comb begin
      rdata = '0;
      if (w_hit) begin
         case (w_off)
            2'd1:    rdata = {16'h0000, w_count8, 4'h0, r_ovf, w_busy, w_empty, w_full};
            2'd2:    rdata = {30'h0, w_odd_rd, r_tx_en};
            default: rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed bench for mmio_uart_tx with a queue-based
// behavioural model (byte FIFO + expected txd waveform) checked every cycle.
module tb_mmio_uart_tx;

   localparam int unsigned DIV   = 4;
   localparam int unsigned DEPTH = 8;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned FBITS    = 11;
   localparam logic [31:0] CTRL_ALL = 32'h3;
`else
   localparam int unsigned FBITS    = 10;
   localparam logic [31:0] CTRL_ALL = 32'h1;
`endif
   localparam logic [31:0] A_TX  = 32'h1000_0000;
   localparam logic [31:0] A_ST  = 32'h1000_0004;
   localparam logic [31:0] A_CT  = 32'h1000_0008;
   localparam logic [31:0] A_RS  = 32'h1000_000C;
   localparam logic [31:0] A_OUT = 32'h1000_0010;

   logic        clk = 1'b0;
   logic        rst, MemRW, hit, txd, irq_empty;
   logic [31:0] Addr_in, Data_in, rdata;

   int checks   = 0;
   int failures = 0;

   mmio_uart_tx #(
      .BASE_ADDR (32'h1000_0000),
      .CLK_DIV   (DIV),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .MemRW    (MemRW),
      .Addr_in  (Addr_in),
      .Data_in  (Data_in),
      .hit      (hit),
      .rdata    (rdata),
      .txd      (txd),
      .irq_empty(irq_empty)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   logic [7:0] m_q[$];
   logic       m_wave[$];
   logic       m_en, m_ovf, m_odd, m_txd, m_busy;
   logic       m_ok = 1'b0;
   logic       m_pop;
   logic [7:0] m_b;
   int         m_osz;

   function automatic void push_level(input logic v);
      repeat (DIV) m_wave.push_back(v);
   endfunction

   function automatic logic [31:0] m_rdata(input logic [31:0] a);
      if (a[31:4] != A_TX[31:4]) return 32'h0;
      case (a[3:2])
         2'd1:    return {16'h0, 8'(m_q.size()), 4'h0, m_ovf, m_busy,
                          (m_q.size() == 0), (m_q.size() == DEPTH)};
         2'd2:    return {30'h0, m_odd, m_en};
         default: return 32'h0;
      endcase
   endfunction

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_q.delete();
         m_wave.delete();
         m_en   = 1'b1;
         m_ovf  = 1'b0;
         m_odd  = 1'b0;
         m_txd  = 1'b1;
         m_busy = 1'b0;
      end else begin
         m_osz = m_q.size();
         m_pop = 1'b0;
         // transmitter picks a new byte only once the previous frame is fully out
         if (m_wave.size() == 0 && m_en && m_osz > 0) begin
            m_pop = 1'b1;
            m_b   = m_q.pop_front();
            push_level(1'b0);
            for (int i = 0; i < 8; i++) push_level(m_b[i]);
`ifdef UART_TX_PARITY_EN
            push_level((^m_b) ^ m_odd);
`endif
            push_level(1'b1);
         end
         if (MemRW && Addr_in[31:4] == A_TX[31:4]) begin
            case (Addr_in[3:2])
               2'd0: if (m_osz < DEPTH || m_pop) m_q.push_back(Data_in[7:0]);
                     else m_ovf = 1'b1;
               2'd1: if (Data_in[3]) m_ovf = 1'b0;
               2'd2: begin
                  m_en = Data_in[0];
`ifdef UART_TX_PARITY_EN
                  m_odd = Data_in[1];
`endif
               end
               default: ;
            endcase
         end
         if (m_wave.size() > 0) begin
            m_txd  = m_wave.pop_front();
            m_busy = 1'b1;
         end else begin
            m_txd  = 1'b1;
            m_busy = 1'b0;
         end
      end
      m_ok = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (m_ok) begin
         chk("txd", txd, m_txd);
         chk("irq_empty", irq_empty, (m_q.size() == 0) && !m_busy);
         chk("hit", hit, Addr_in[31:4] == A_TX[31:4]);
         chk("rdata", rdata, m_rdata(Addr_in));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      MemRW   = 1'b1;
      Addr_in = a;
      Data_in = d;
      @(posedge clk);
      #2;
      MemRW = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_h);
      Addr_in = a;
      @(negedge clk);
      chk({nm, "_rdata"}, rdata, exp_d);
      chk({nm, "_hit"}, hit, exp_h);
      @(posedge clk);
      #2;
   endtask

   // called right after the commit of a store to an idle, empty UART
   task automatic frame_lit(input string nm, input logic [10:0] lv, input int nbits);
      @(negedge clk);
      chk({nm, "_pre"}, txd, 1'b1);
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < int'(DIV); c++) begin
            @(negedge clk);
            chk({nm, "_bit"}, txd, lv[b]);
            chk({nm, "_busy_irq"}, irq_empty, 1'b0);
         end
      end
      @(negedge clk);
      chk({nm, "_done_irq"}, irq_empty, 1'b1);
      @(posedge clk);
      #2;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      logic [10:0] lv;
      rst     = 1'b1;
      MemRW   = 1'b0;
      Addr_in = A_ST;
      Data_in = '0;
      repeat (2) @(posedge clk);
      #2;
      @(negedge clk);
      chk("rst_txd", txd, 1'b1);
      chk("rst_irq", irq_empty, 1'b1);
      chk("rst_status", rdata, 32'h0000_0002);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // register map reads while idle
      rd_chk("st", A_ST, 32'h2, 1'b1);
      rd_chk("st_lsb", 32'h1000_0006, 32'h2, 1'b1);
      rd_chk("ctrl", A_CT, 32'h1, 1'b1);
      rd_chk("rsv", A_RS, 32'h0, 1'b1);
      rd_chk("txdata", A_TX, 32'h0, 1'b1);
      rd_chk("out", A_OUT, 32'h0, 1'b0);
      rd_chk("below", 32'h0FFF_FFFC, 32'h0, 1'b0);

      wr(A_CT, 32'hFFFF_FFFF);
      rd_chk("ctrl_all", A_CT, CTRL_ALL, 1'b1);
      wr(A_CT, 32'h1);
      rd_chk("ctrl_one", A_CT, 32'h1, 1'b1);

      // stores that must not reach the FIFO
      wr(A_RS, 32'h5A);
      wr(A_OUT, 32'h5A);
      repeat (8) @(posedge clk);
      #2;
      rd_chk("ign", A_ST, 32'h2, 1'b1);

      // single frame 0xA5 from idle
      wr(A_TX, 32'hA5);
`ifdef UART_TX_PARITY_EN
      lv = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
      lv = {1'b0, 1'b1, 8'hA5, 1'b0};
`endif
      frame_lit("a5", lv, FBITS);

      // back-to-back frames
      wr(A_TX, 32'h11);
      wr(A_TX, 32'h22);
      Addr_in = A_ST;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (i == 5) chk("b2b_count", rdata[15:8], 8'd1);
         if (irq_empty) break;
         n++;
      end
      chk("b2b_len", n, 2 * FBITS * DIV);
      @(posedge clk);
      #2;

      // overflow with tx disabled, then drain
      wr(A_CT, 32'h0);
      for (int i = 0; i < 10; i++) wr(A_TX, 32'h30 + i);
      Addr_in = A_ST;
      @(negedge clk);
      chk("ovf_status", rdata, 32'h0000_0809);
      @(posedge clk);
      #2;
      wr(A_ST, 32'h8);
      @(negedge clk);
      chk("ovf_clear", rdata, 32'h0000_0801);
      @(posedge clk);
      #2;
      wr(A_CT, 32'h1);
      wr(A_TX, 32'h3A);  // lands on the first pop edge, so a full FIFO accepts it
      Addr_in = A_ST;
      n = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (i == 0) chk("ovf_pushpop", rdata, 32'h0000_0805);
         if (irq_empty) break;
         n++;
      end
      chk("ovf_drain_len", n, 9 * FBITS * DIV);
      @(posedge clk);
      #2;

      // reset during data bit 3 of 0xC3
      wr(A_TX, 32'hC3);
      repeat (18) @(posedge clk);
      #2;
      rst     = 1'b1;
      Addr_in = A_ST;
      @(negedge clk);
      chk("rst_mid_txd_before", txd, 1'b0);
      @(negedge clk);
      chk("rst_mid_txd", txd, 1'b1);
      chk("rst_mid_irq", irq_empty, 1'b1);
      chk("rst_mid_status", rdata, 32'h0000_0002);
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("rst_quiet", txd, 1'b1);
      end
      @(posedge clk);
      #2;

`ifdef UART_TX_PARITY_EN
      wr(A_CT, 32'h3);
      wr(A_TX, 32'h07);
      lv = {1'b1, 1'b0, 8'h07, 1'b0};
      frame_lit("par", lv, 11);
`endif

      repeat (4) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data port, downstream of the core.
- Consumes the core's `Addr_out`, `MemRW` and `Data_out`. Returns read data combinationally, so the single-cycle `lw` path needs no wait states.
- Buffers stored bytes in a small FIFO and serialises them 8N1, LSB first, on `txd`.
- The top-level mux selects `rdata` when `hit` is asserted.

Parameters:
- BASE_ADDR, 32'h1000_0000: base of the 16-byte register window; must be 16-byte aligned.
- CLK_DIV, 868: clock cycles per bit. Legal range is 2..65535.
- FIFO_DEPTH, 8: TX FIFO entries. Must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRW  in  1  store strobe from the core; 1 = write this cycle.
- Addr_in  in  32  byte address from the core's ALU result.
- Data_in  in  32  store data from the core, already lane-shifted.
- hit  out  1  combinational; 1 when Addr_in[31:4] == BASE_ADDR[31:4].
- rdata  out  32  combinational read data; 0 when hit=0.
- txd  out  1  serial output; idle level is 1.
- irq_empty  out  1  registered; 1 when the FIFO is empty and the FSM is IDLE.

Behaviour:
- Register map. Offsets come from Addr_in[3:2]; Addr_in[1:0] is ignored.
  - 0x0 TXDATA: a write pushes Data_in[7:0]. Reads return 0.
  - 0x4 STATUS (read):
    - bit0 full
    - bit1 empty
    - bit2 busy (FSM != IDLE)
    - bit3 overflow (sticky)
    - bits[15:8] FIFO count
    - all other bits 0
  - 0x4 STATUS (write): writing 1 to bit3 clears overflow. All other bits are ignored.
  - 0x8 CTRL: read/write. bit0 tx_en; all other bits read 0.
  - 0xC: reserved. Reads return 0; writes are ignored.
- Write commit: on the clk edge where MemRW=1 and hit=1. One commit per cycle the strobe is high.
- Reset values:
  - txd=1, irq_empty=1
  - FSM=IDLE, FIFO empty (pointers and count 0)
  - overflow=0, tx_en=1
  - baud counter=0, shift register=0
- Reset has priority over any write or transmit in progress. A frame cut off mid-bit ends with txd=1 on the next cycle.
- FIFO push rules:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow is set on that edge.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If tx_en && !empty: pop the head into shift[7:0], load baud=CLK_DIV-1, set bitcnt=0, go to START.
  - START: txd=0. When baud==0: reload baud, go to DATA. Otherwise decrement baud.
  - DATA: txd=shift[0]. When baud==0: shift right, bitcnt++, reload baud. After bitcnt reaches 7 and that bit completes, go to STOP.
  - STOP: txd=1. When baud==0:
    - if tx_en && !empty: pop, reload, go directly to START, with no idle gap between frames;
    - otherwise go to IDLE.
- Timing:
  - Every bit lasts exactly CLK_DIV cycles, so a frame is exactly 10*CLK_DIV cycles.
  - txd is driven from a register, so txd falls one cycle after the commit edge of a write to an idle, empty UART.
- tx_en=0 only stops new pops. A frame in progress always completes.
- irq_empty is updated on each edge from the next-state values.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP; it lasts CLK_DIV cycles and drives the parity bit.
  - Parity is the XOR of the 8 data bits, inverted when CTRL bit1 (odd) is 1.
  - CTRL bit1 is read/write and resets to 0.
  - A frame is 11*CLK_DIV cycles.
- When not defined: no PARITY state, CTRL bit1 reads 0 and ignores writes, frame is 10*CLK_DIV cycles.

Test Plan:
- Bench runs with CLK_DIV=4. Store 0xA5 to 0x1000_0000 from idle -> txd low starts 1 cycle after the commit edge; txd sequence is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; irq_empty returns to 1 after 40 cycles.
- Store 0x11, then 0x22, on consecutive cycles -> two frames back to back with no idle cycle between them (80 cycles total); STATUS count reads 1 during frame 1.
- Store 10 bytes with tx_en=0 (FIFO_DEPTH=8) -> STATUS reads full=1, count=8, overflow=1. Writing 0x8 to STATUS reads back overflow=0, count=8. Setting tx_en=1 transmits the first 8 bytes in order.
- Assert rst during DATA bit 3 -> next cycle txd=1, STATUS=0x0000_0002, irq_empty=1; no further toggling on txd.
- Read 0x1000_0004 while idle -> rdata=0x0000_0002, hit=1. Read 0x1000_0010 -> hit=0, rdata=0.
- With UART_TX_PARITY_EN and CTRL=0x3, send 0x07 -> parity bit is 0 (three ones, odd parity), stop bit follows, frame is 44 cycles.
